// File: rtl/icache_rd_arb_if.sv
// Signal bundle between the fetch/prefetch requesters, the icache read port
// and the icache read arbiter.
interface icache_rd_arb_if;
  logic        fe0_read_req;
  logic [8:0]  fe0_read_asid;
  logic [31:2] fe0_read_addr;
  logic        fe0_specid;

  logic        pf_valid;
  logic        pf_ready;
  logic [8:0]  pf_asid;
  logic [31:2] pf_addr;
  logic        pf_done;
  logic        pf_drop;

  logic        de_setpc;
  logic        csr_setpc;

  logic        ic_req;
  logic [8:0]  ic_asid;
  logic [31:2] ic_addr;
  logic        ic_specid;
  logic        ic_src;

  logic        arb_fe_hold;
  logic        arb_err;

  // Requester/consumer side: drives requests, observes the arbitrated port.
  modport master (
    output fe0_read_req, fe0_read_asid, fe0_read_addr, fe0_specid,
    output pf_valid, pf_asid, pf_addr, de_setpc, csr_setpc,
    input  pf_ready, pf_done, pf_drop,
    input  ic_req, ic_asid, ic_addr, ic_specid, ic_src,
    input  arb_fe_hold, arb_err
  );

  // Arbiter side.
  modport slave (
    input  fe0_read_req, fe0_read_asid, fe0_read_addr, fe0_specid,
    input  pf_valid, pf_asid, pf_addr, de_setpc, csr_setpc,
    output pf_ready, pf_done, pf_drop,
    output ic_req, ic_asid, ic_addr, ic_specid, ic_src,
    output arb_fe_hold, arb_err
  );
endinterface

// File: rtl/icache_rd_arb.sv
// Arbitrates the icache read port between fetch0 and a one-entry prefetch
// buffer; fetch normally wins, a starvation counter eventually forces prefetch.
module icache_rd_arb #(
  parameter int STARVE_MAX = 8
) (
  input logic           clk_core,
  input logic           reset_n,
  icache_rd_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;

  localparam logic [2:0] STARVE_LAST = 3'(STARVE_MAX - 1);

  state_t      state, state_nxt;
  logic [2:0]  starve_cnt, starve_cnt_nxt;
  logic [8:0]  hold_asid;
  logic [31:2] hold_addr;
  logic        err_q;

  logic pf_ready_w, capture, redirect, line_match;
  logic fe_grant, pf_grant, drop_w, err_set;

  assign pf_ready_w = (state == IDLE) & reset_n;
  assign capture    = bus.pf_valid & pf_ready_w;
  assign redirect   = bus.de_setpc | bus.csr_setpc;
  assign line_match = (bus.fe0_read_addr[31:5] == hold_addr[31:5]) &&
                      (bus.fe0_read_asid == hold_asid);

  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state      <= IDLE;
      starve_cnt <= 3'd0;
      hold_asid  <= 9'd0;
      hold_addr  <= 30'd0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      if (capture) begin
        hold_asid <= bus.pf_asid;
        hold_addr <= bus.pf_addr;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    fe_grant       = 1'b0;
    pf_grant       = 1'b0;
    drop_w         = 1'b0;
    err_set        = 1'b0;
    case (state)
      IDLE: begin
        fe_grant = bus.fe0_read_req;
        if (capture) state_nxt = PEND;
      end
      PEND: begin
        fe_grant = bus.fe0_read_req;
        if (redirect || !bus.fe0_read_req || line_match) begin
          // Redirect or same-line fetch makes the prefetch pointless.
          pf_grant       = !redirect && !bus.fe0_read_req;
          drop_w         = !pf_grant;
          state_nxt      = IDLE;
          starve_cnt_nxt = 3'd0;
        end else if (starve_cnt == STARVE_LAST) begin
          state_nxt      = HOLD;
          starve_cnt_nxt = 3'd0;
        end else begin
          starve_cnt_nxt = starve_cnt + 3'd1;
        end
      end
      HOLD: begin
        // Fetch is stalled via arb_fe_hold; a request here is a protocol error.
        err_set        = bus.fe0_read_req;
        state_nxt      = IDLE;
        starve_cnt_nxt = 3'd0;
        if (redirect) begin
          drop_w   = 1'b1;
          fe_grant = bus.fe0_read_req;
        end else begin
          pf_grant = 1'b1;
        end
      end
      default: begin
        state_nxt      = IDLE;
        starve_cnt_nxt = 3'd0;
      end
    endcase
  end

  // Pulses are suppressed while reset is applied so a discarded prefetch is silent.
  assign bus.pf_ready    = pf_ready_w;
  assign bus.pf_done     = pf_grant & reset_n;
  assign bus.pf_drop     = drop_w & reset_n;
  assign bus.ic_req      = fe_grant | (pf_grant & reset_n);
  assign bus.ic_src      = pf_grant & reset_n;
  assign bus.ic_asid     = fe_grant ? bus.fe0_read_asid : hold_asid;
  assign bus.ic_addr     = fe_grant ? bus.fe0_read_addr : hold_addr;
  assign bus.ic_specid   = fe_grant & bus.fe0_specid;
  assign bus.arb_fe_hold = (state == HOLD);
  assign bus.arb_err     = err_q;

endmodule

// File: doc/icache_rd_arb.md
ICACHE_RD_ARB -- requirements
Module: icache_rd_arb

Interface
REQ-001 SHALL have ports: clk_core  in  1  core clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have ports: fe0_read_req  in  1  fetch0 icache read request.
REQ-004 SHALL have ports: fe0_read_asid  in  9; fe0_read_addr  in  [31:2]; fe0_specid  in  1  fetch0 request fields.
REQ-005 SHALL have ports: pf_valid  in  1; pf_ready  out  1; pf_asid  in  9; pf_addr  in  [31:2]  prefetcher request handshake.
REQ-006 SHALL have ports: pf_done  out  1  one-cycle pulse, prefetch issued to icache; pf_drop  out  1  one-cycle pulse, prefetch discarded.
REQ-007 SHALL have ports: de_setpc  in  1; csr_setpc  in  1  redirect indications (cancel pending prefetch).
REQ-008 SHALL have ports: ic_req  out  1; ic_asid  out  9; ic_addr  out  [31:2]; ic_specid  out  1; ic_src  out  1 (0=fetch, 1=prefetch)  arbitrated icache port.
REQ-009 SHALL have ports: arb_fe_hold  out  1  registered stall to fetch0 (ORed into fetch stall by integrator); arb_err  out  1  sticky protocol-error flag.
REQ-010 Parameter: STARVE_MAX, default 8, consecutive fetch wins before prefetch forced.

Function
REQ-011 SHALL implement FSM states IDLE, PEND, HOLD with a one-entry prefetch holding register (asid, addr) and a 3-bit starvation counter.
REQ-012 pf_ready SHALL equal (state==IDLE) & reset_n; handshake pf_valid&pf_ready captures pf_asid/pf_addr and moves IDLE->PEND next cycle; minimum capture-to-issue latency 1 cycle.
REQ-013 In IDLE and PEND, fe0_read_req SHALL win: ic_req=1, ic_src=0, ic_asid/ic_addr/ic_specid = fe0 fields, same cycle (combinational pass-through).
REQ-014 PEND with fe0_read_req=0 and no redirect SHALL issue prefetch: ic_req=1, ic_src=0->1, ic_addr/asid from holding register, ic_specid=0, pf_done=1; next state IDLE, counter cleared.
REQ-015 PEND with fe0_read_req=1 and fe0_read_addr[31:5]==held addr[31:5] (same 32-byte line) and fe0_read_asid==held asid SHALL drop the prefetch: pf_drop=1, next IDLE, counter cleared.
REQ-016 PEND with fe0_read_req=1 and no line match SHALL increment counter; when counter reaches STARVE_MAX-1 before increment, next state HOLD, counter cleared.
REQ-017 arb_fe_hold SHALL be 1 exactly while state==HOLD (registered, no combinational path from inputs).
REQ-018 In HOLD, prefetch SHALL win unconditionally: issue as REQ-014, next IDLE; if fe0_read_req=1 in HOLD, fetch request is not forwarded and arb_err sets (sticky until reset).
REQ-019 de_setpc|csr_setpc in PEND or HOLD SHALL take priority over prefetch issue: no prefetch issued, pf_drop=1, next IDLE, counter cleared; a simultaneous fe0_read_req is still forwarded per REQ-013.
REQ-020 Redirect in IDLE SHALL NOT block a same-cycle pf capture; the captured prefetch is kept.
REQ-021 ic_req=0 when neither fetch nor prefetch is granted; ic_addr/asid SHALL then be don't-care but driven (no X).
REQ-022 pf_done and pf_drop SHALL never assert in the same cycle; at most one grant per cycle.

Reset
REQ-023 While reset_n=0 at a clock edge: state IDLE, counter 0, holding register 0, arb_fe_hold 0, arb_err 0; pf_ready 0 during reset, 1 the first cycle after.
REQ-024 Reset mid-operation (PEND or HOLD) SHALL discard the held prefetch without pf_drop pulse.

Verification
REQ-025 Idle fetch: pf_valid=1 addr 0x40 (byte 0x100), fe0_read_req=0 -> next cycle ic_req=1, ic_src=1, ic_addr=0x40, pf_done=1, pf_ready returns 1 cycle after.
REQ-026 Starvation: prefetch pending, fe0_read_req=1 continuously to non-matching lines -> 8 fetch grants, then arb_fe_hold=1 one cycle, prefetch issued in that cycle, then IDLE.
REQ-027 Line match: held addr byte 0x1000, fe0 fetch byte 0x101C same asid -> pf_drop=1, fetch forwarded, no pf_done.
REQ-028 Redirect: PEND with de_setpc=1 and fe0_read_req=0 -> ic_req=0, pf_drop=1, next IDLE; repeat in HOLD with csr_setpc -> same.
REQ-029 Protocol error: in HOLD, fe0_read_req=1 -> ic_src=1, arb_err=1 and stays 1 until reset_n=0.
REQ-030 Reset in HOLD: reset_n=0 one cycle -> arb_fe_hold=0, pf_ready=0 then 1, no pf_done/pf_drop.
